// File: rtl/song_recorder_if.sv
// song_recorder_if
//   Bundles the note-capture strobe/fields coming from the hit decoder and the
//   replay read port consumed by the song selection mux.
//   master : hit decoder / replay consumer side (drives note fields, rd_idx)
//   slave  : song_recorder side (samples note fields, returns rd_* data)
//   Signals:
//     note_vld                  one-cycle strobe per struck note
//     octave / note / length    note fields, valid with note_vld
//     rd_idx                    replay read index
//     rd_octave/rd_note/rd_length/rd_gap  entry at rd_idx, one cycle later
interface song_recorder_if #(
  parameter int OCT_W  = 2,
  parameter int NOTE_W = 3,
  parameter int LEN_W  = 3,
  parameter int GAP_W  = 16,
  parameter int ADDR_W = 6
);
  logic              note_vld;
  logic [OCT_W-1:0]  octave;
  logic [NOTE_W-1:0] note;
  logic [LEN_W-1:0]  length;
  logic [ADDR_W-1:0] rd_idx;
  logic [OCT_W-1:0]  rd_octave;
  logic [NOTE_W-1:0] rd_note;
  logic [LEN_W-1:0]  rd_length;
  logic [GAP_W-1:0]  rd_gap;

  modport master (
    output note_vld, octave, note, length, rd_idx,
    input  rd_octave, rd_note, rd_length, rd_gap
  );

  modport slave (
    input  note_vld, octave, note, length, rd_idx,
    output rd_octave, rd_note, rd_length, rd_gap
  );
endinterface

// File: rtl/song_recorder.sv
// song_recorder
//   Free-play capture engine. Stores each struck note (octave, note, length,
//   inter-note gap) into a track RAM so a take can be replayed and scored like
//   a built-in song. Read port is synchronous with one cycle of latency and
//   read-before-write behaviour.
//   Optional feature macro: SONG_RECORDER_GAP_EN
//     defined   : gap (system_clock delta, saturating) is stored and returned
//     undefined : no gap storage, no last_stamp register, rd_gap reads 0
//   Ports:
//     i_clk, i_rst        clock, synchronous active-high reset
//     i_arm, i_stop       take control pulses (stop wins when both asserted)
//     i_system_clock      free-running tick counter
//     bus (slave)         note capture strobe/fields and replay read port
//     o_track             number of stored entries
//     o_recording         high while ARMED or REC
//     o_full              track == DEPTH
//     o_overflow          sticky: a note was dropped because the track was full
module song_recorder #(
  parameter int OCT_W  = 2,
  parameter int NOTE_W = 3,
  parameter int LEN_W  = 3,
  parameter int CLK_W  = 32,
  parameter int GAP_W  = 16,
  parameter int DEPTH  = 64,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_arm,
  input  logic               i_stop,
  input  logic [CLK_W-1:0]   i_system_clock,
  song_recorder_if.slave     bus,
  output logic [ADDR_W:0]    o_track,
  output logic               o_recording,
  output logic               o_full,
  output logic               o_overflow
);

`ifdef SONG_RECORDER_GAP_EN
  localparam int ENT_W = OCT_W + NOTE_W + LEN_W + GAP_W;
`else
  localparam int ENT_W = OCT_W + NOTE_W + LEN_W;
`endif
  localparam logic [ADDR_W:0] TRK_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] TRK_ONE  = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_REC   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  logic [ADDR_W:0]   r_track;
  logic              r_overflow;
  logic [ENT_W-1:0]  r_mem [DEPTH];
  logic [ENT_W-1:0]  r_rd;

  logic              w_recording;
  logic              w_full;
  logic              w_restart;
  logic              w_note_take;
  logic              w_write;
  logic [ENT_W-1:0]  w_entry;

  assign w_recording = (r_state == ST_ARMED) || (r_state == ST_REC);
  assign w_full      = (r_track == TRK_FULL);
  // A stop that acts (ARMED/REC) overrides a simultaneous arm.
  assign w_restart   = i_arm & ~(i_stop & w_recording);
  // A note arriving with a restart belongs to the discarded take.
  assign w_note_take = w_recording & bus.note_vld & ~w_restart;
  assign w_write     = w_note_take & ~w_full;

`ifdef SONG_RECORDER_GAP_EN
  logic [CLK_W-1:0] r_last_stamp;
  logic [CLK_W-1:0] w_delta;
  logic [GAP_W-1:0] w_gap;

  // Modulo subtraction absorbs a wrap of the free-running counter.
  assign w_delta = i_system_clock - r_last_stamp;

  // Gap before the incoming note: zero for the first note, else saturated delta.
  always_comb begin
    w_gap = {GAP_W{1'b0}};
    if (r_state == ST_ARMED) begin
      w_gap = {GAP_W{1'b0}};
    end else if (|w_delta[CLK_W-1:GAP_W]) begin
      w_gap = {GAP_W{1'b1}};
    end else begin
      w_gap = w_delta[GAP_W-1:0];
    end
  end

  assign w_entry = {bus.octave, bus.note, bus.length, w_gap};

  // Timestamp of the most recently stored note.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_stamp <= {CLK_W{1'b0}};
    end else if (w_write) begin
      r_last_stamp <= i_system_clock;
    end else begin
      r_last_stamp <= r_last_stamp;
    end
  end

  assign bus.rd_gap = r_rd[GAP_W-1:0];
`else
  logic w_unused_clk;
  assign w_unused_clk = ^i_system_clock;
  assign w_entry      = {bus.octave, bus.note, bus.length};
  assign bus.rd_gap   = {GAP_W{1'b0}};
`endif

  // Take-control FSM with track counter and sticky overflow flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_track    <= {(ADDR_W+1){1'b0}};
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_restart) r_state <= ST_ARMED;
          else           r_state <= ST_IDLE;
        end
        ST_ARMED, ST_REC: begin
          if (i_stop)         r_state <= ST_DONE;
          else if (w_restart) r_state <= ST_ARMED;
          else if (w_write)   r_state <= ST_REC;
          else                r_state <= r_state;
        end
        ST_DONE: begin
          if (w_restart) r_state <= ST_ARMED;
          else           r_state <= ST_DONE;
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_restart) begin
        r_track    <= {(ADDR_W+1){1'b0}};
        r_overflow <= 1'b0;
      end else begin
        if (w_write) r_track <= r_track + TRK_ONE;
        else         r_track <= r_track;
        if (w_note_take && w_full) r_overflow <= 1'b1;
        else                       r_overflow <= r_overflow;
      end
    end
  end

  // Track RAM write port; contents survive reset and arm.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_write) begin
      r_mem[r_track[ADDR_W-1:0]] <= w_entry;
    end
  end

  // Replay read port: registered, returns pre-write data on a same-cycle hit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd <= {ENT_W{1'b0}};
    end else begin
      r_rd <= r_mem[bus.rd_idx];
    end
  end

  assign bus.rd_octave = r_rd[ENT_W-1 -: OCT_W];
  assign bus.rd_note   = r_rd[ENT_W-OCT_W-1 -: NOTE_W];
  assign bus.rd_length = r_rd[ENT_W-OCT_W-NOTE_W-1 -: LEN_W];

  assign o_track     = r_track;
  assign o_recording = w_recording;
  assign o_full      = w_full;
  assign o_overflow  = r_overflow;

endmodule
